// File: rtl/irig_frame_decoder.sv
// IRIG pulse-width time-code frame decoder with pin-referred frame timestamp and AXI4-Stream output.
// Define IRIG_GLITCH_FILTER_EN to insert a GLITCH_CYCLES-deep input filter after the synchroniser.
module irig_frame_decoder #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int BIT_RATE_HZ   = 100,
  parameter int FRAME_BITS    = 100,
  parameter int COUNTER_WIDTH = 64,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [COUNTER_WIDTH-1:0]            counter_in,
  input  logic                                irig_in,
  output logic [FRAME_BITS+COUNTER_WIDTH-1:0] m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic                                locked,
  output logic [15:0]                         err_count,
  output logic [15:0]                         drop_count
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BIT_RATE_HZ;
  localparam int WMAX       = 2 * BIT_CYCLES;
  localparam int CW         = $clog2(WMAX + 1);
  localparam int IDXW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [CW-1:0] WMAX_C   = CW'(WMAX);
  localparam logic [CW-1:0] T2_C     = CW'(BIT_CYCLES * 2 / 20);
  localparam logic [CW-1:0] T7_C     = CW'(BIT_CYCLES * 7 / 20);
  localparam logic [CW-1:0] T13_C    = CW'(BIT_CYCLES * 13 / 20);
  localparam logic [CW-1:0] T18_C    = CW'(BIT_CYCLES * 18 / 20);
  localparam logic [CW-1:0] PER_LO_C = CW'(BIT_CYCLES - BIT_CYCLES / 16);
  localparam logic [CW-1:0] PER_HI_C = CW'(BIT_CYCLES + BIT_CYCLES / 16);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_MARK, SYM_BAD} sym_t;
  typedef enum logic [1:0] {HUNT, HUNT_P, LOCKED} state_t;

  // Front end: synchroniser and optional filter
  logic sync1_q, sync2_q, lvl, lvl_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= irig_in;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef IRIG_GLITCH_FILTER_EN
  localparam int LAT = 2 + GLITCH_CYCLES;
  localparam int GCW = $clog2(GLITCH_CYCLES + 1);

  logic           filt_q;
  logic [GCW-1:0] filt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (filt_cnt_q == GCW'(GLITCH_CYCLES - 1)) begin
        filt_q     <= sync2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + GCW'(1);
      end
    end else begin
      filt_cnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  // GLITCH_CYCLES has no effect without the filter.
  localparam int LAT = 2 + 0 * GLITCH_CYCLES;

  assign lvl = sync2_q;
`endif

  logic rise, fall;
  assign rise = lvl & ~lvl_prev_q;
  assign fall = ~lvl & lvl_prev_q;

  // Width, period and loss-of-signal measurement
  logic [CW-1:0]            width_q, period_q;
  logic                     los_q;
  logic [COUNTER_WIDTH-1:0] cand_ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      width_q   <= '0;
      period_q  <= '0;
      los_q     <= 1'b0;
      cand_ts_q <= '0;
    end else begin
      if (rise) begin
        width_q   <= CW'(1);
        period_q  <= CW'(1);
        los_q     <= 1'b0;
        cand_ts_q <= counter_in - COUNTER_WIDTH'(LAT);
      end else begin
        if (lvl && width_q != WMAX_C) width_q <= width_q + CW'(1);
        if (period_q != WMAX_C) period_q <= period_q + CW'(1);
        if (period_q == WMAX_C) los_q <= 1'b1;
      end
    end
  end

  sym_t sym;
  always_comb begin
    sym = SYM_BAD;
    if (width_q < T2_C)       sym = SYM_BAD;
    else if (width_q < T7_C)  sym = SYM_ZERO;
    else if (width_q < T13_C) sym = SYM_ONE;
    else if (width_q < T18_C) sym = SYM_MARK;
    else                      sym = SYM_BAD;
  end

  logic [FRAME_BITS-1:0] marker_mask;
  for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_marker
    assign marker_mask[gi] = ((gi + 1) % 10 == 0);
  end

  state_t                   state_q;
  logic [IDXW-1:0]          idx_q;
  logic [FRAME_BITS-1:0]    frame_q;
  logic [COUNTER_WIDTH-1:0] frame_ts_q;

  logic los_ev, period_err, mark_violation, sym_err, err_any, new_frame;
  logic [FRAME_BITS-1:0] frame_full;

  assign los_ev         = (period_q == WMAX_C) && !los_q;
  assign period_err     = rise && ((period_q < PER_LO_C) || (period_q > PER_HI_C));
  // Index 0 is the reference marker; elsewhere markers sit only at every tenth position.
  assign mark_violation = (idx_q == '0) ? (sym != SYM_MARK)
                                        : ((sym == SYM_MARK) != marker_mask[idx_q]);
  assign sym_err        = fall && ((sym == SYM_BAD) || ((state_q == LOCKED) && mark_violation));
  assign err_any        = (state_q != HUNT) && (sym_err || period_err || los_ev);
  assign new_frame      = (state_q == LOCKED) && fall && !err_any && (idx_q == LAST_IDX);
  assign frame_full     = frame_q | ({{(FRAME_BITS-1){1'b0}}, (sym == SYM_ONE)} << idx_q);

  logic [FRAME_BITS+COUNTER_WIDTH-1:0] tdata_q;
  logic                                tvalid_q, locked_q;
  logic [15:0]                         err_count_q, drop_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      frame_q      <= '0;
      frame_ts_q   <= '0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
      drop_count_q <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (fall && sym == SYM_MARK) state_q <= HUNT_P;
        end
        HUNT_P: begin
          if (err_any) begin
            state_q <= HUNT;
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
          end else if (fall) begin
            if (sym == SYM_MARK) begin
              frame_ts_q <= cand_ts_q;
              frame_q    <= '0;
              idx_q      <= IDXW'(1);
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
            end else begin
              state_q <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (err_any) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            idx_q    <= '0;
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
          end else if (fall) begin
            if (idx_q == '0) begin
              frame_ts_q <= cand_ts_q;
              frame_q    <= '0;
              idx_q      <= IDXW'(1);
            end else begin
              frame_q <= frame_full;
              idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
            end
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase

      // A held beat is never overwritten; a frame arriving behind a stalled beat is counted as dropped.
      if (new_frame) begin
        if (!tvalid_q || m_axis_tready) begin
          tdata_q  <= {frame_ts_q, frame_full};
          tvalid_q <= 1'b1;
        end else if (drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q;
  assign locked        = locked_q;
  assign err_count     = err_count_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_irig_frame_decoder.sv
// Scoreboard bench for irig_frame_decoder, scaled to 100 clocks per symbol and 20-symbol frames.
module tb_irig_frame_decoder;

  localparam int CLK_HZ = 10_000;
  localparam int RATE   = 100;
  localparam int B      = CLK_HZ / RATE;
  localparam int FB     = 20;
  localparam int CWID   = 64;
  localparam int DW     = FB + CWID;
  localparam int W0     = 20;
  localparam int W1     = 50;
  localparam int WP     = 80;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CWID-1:0] counter_in = 64'hFFFF_FFFF_FFFF_F000;
  logic            irig_in = 1'b0;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic            locked;
  logic [15:0]     err_count;
  logic [15:0]     drop_count;

  irig_frame_decoder #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .BIT_RATE_HZ  (RATE),
    .FRAME_BITS   (FB),
    .COUNTER_WIDTH(CWID),
    .GLITCH_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .counter_in   (counter_in),
    .irig_in      (irig_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .locked       (locked),
    .err_count    (err_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) counter_in <= counter_in + 64'd1;

  logic [DW-1:0]   exp_q[$];
  int              checks = 0;
  int              fails = 0;
  int              beats = 0;
  int              wv[FB];
  int              glitch_idx = -1;
  logic [CWID-1:0] last_rise_ts;

  // Output monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      logic [DW-1:0] e;
      beats++;
      $display("beat %0d: ts=%h bits=%h", beats, m_axis_tdata[DW-1:FB], m_axis_tdata[FB-1:0]);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got tdata=%h, required no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e) begin
          fails++;
          $display("FAIL beat_data: got %h, required %h", m_axis_tdata, e);
        end
      end
      checks++;
      if (m_axis_tlast !== 1'b1) begin
        fails++;
        $display("FAIL beat_tlast: got %b, required 1", m_axis_tlast);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic send_one(input int w);
    for (int c = 0; c < B; c++) begin
      @(posedge clk); #1;
      irig_in = (c < w);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int c = 0; c < B; c++) begin
        @(posedge clk); #1;
        irig_in = (c < wv[i]) || (i == glitch_idx && c >= 60 && c < 62);
        if (c == 0) last_rise_ts = counter_in;
      end
    end
  endtask

  function automatic void fill(input logic [FB-1:0] bits);
    for (int i = 0; i < FB; i++)
      wv[i] = (i == 0 || (i + 1) % 10 == 0) ? WP : (bits[i] ? W1 : W0);
  endfunction

  task automatic send_frame(input bit expect_beat);
    logic [FB-1:0] b;
    for (int i = 0; i < FB; i++) b[i] = (wv[i] == W1);
    send_range(0, 0);
    if (expect_beat) exp_q.push_back({last_rise_ts, b});
    send_range(1, FB - 1);
  endtask

  task automatic check_out(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_out("reset_tvalid", DW'(m_axis_tvalid), '0);
    check_out("reset_tlast", DW'(m_axis_tlast), '0);
    check_out("reset_tdata", m_axis_tdata, '0);
    check_out("reset_locked", DW'(locked), '0);
    check_out("reset_err", DW'(err_count), '0);
    check_out("reset_drop", DW'(drop_count), '0);
  endtask

  task automatic test_nominal_lock();
    int b0;
    do_reset();
    m_axis_tready = 1'b1;
    b0 = beats;
    send_one(WP);
    fill(20'h00002);
    send_frame(1);
    send_one(WP);
    check_out("nominal_beats", DW'(beats - b0), DW'(1));
    check_out("nominal_pending", DW'(exp_q.size()), '0);
    check_out("nominal_locked", DW'(locked), DW'(1));
    check_out("nominal_err", DW'(err_count), '0);
  endtask

  task automatic test_back_pressure();
    int b0;
    logic [DW-1:0] held;
    do_reset();
    m_axis_tready = 1'b0;
    b0 = beats;
    send_one(WP);
    fill(20'h5A5A5);
    send_frame(1);
    held = exp_q[0];
    fill(20'h3C3C3);
    send_frame(0);
    send_one(WP);
    check_out("bp_tvalid_held", DW'(m_axis_tvalid), DW'(1));
    check_out("bp_tdata_held", m_axis_tdata, held);
    check_out("bp_drop", DW'(drop_count), DW'(1));
    check_out("bp_no_beat", DW'(beats - b0), '0);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_out("bp_one_beat", DW'(beats - b0), DW'(1));
    check_out("bp_tvalid_clear", DW'(m_axis_tvalid), '0);
    check_out("bp_pending", DW'(exp_q.size()), '0);
  endtask

  task automatic test_bad_width();
    int b0;
    do_reset();
    m_axis_tready = 1'b1;
    b0 = beats;
    send_one(WP);
    fill(20'h12345);
    wv[12] = 6;
    send_frame(0);
    check_out("badw_err", DW'(err_count), DW'(1));
    check_out("badw_locked", DW'(locked), '0);
    check_out("badw_no_beat", DW'(beats - b0), '0);
    fill(20'h0F0F0);
    send_frame(1);
    send_one(WP);
    check_out("badw_relock_beat", DW'(beats - b0), DW'(1));
    check_out("badw_relock_locked", DW'(locked), DW'(1));
    check_out("badw_err_stable", DW'(err_count), DW'(1));
  endtask

  task automatic test_marker();
    int b0;
    do_reset();
    m_axis_tready = 1'b1;
    b0 = beats;
    send_one(WP);
    fill(20'h00000);
    wv[5] = WP;
    send_frame(0);
    check_out("mark5_err", DW'(err_count), DW'(1));
    check_out("mark5_locked", DW'(locked), '0);
    fill(20'h00402);
    send_frame(1);
    fill(20'h00000);
    wv[19] = W0;
    send_frame(0);
    check_out("mark19_err", DW'(err_count), DW'(2));
    check_out("mark19_locked", DW'(locked), '0);
    check_out("mark_beats", DW'(beats - b0), DW'(1));
    check_out("mark_pending", DW'(exp_q.size()), '0);
  endtask

  task automatic test_los();
    int b0;
    do_reset();
    m_axis_tready = 1'b1;
    b0 = beats;
    send_one(WP);
    fill(20'hABCDE);
    send_frame(1);
    send_one(WP);
    check_out("los_pre_locked", DW'(locked), DW'(1));
    check_out("los_pre_err", DW'(err_count), '0);
    repeat (2 * B + 1) @(posedge clk);
    #1;
    check_out("los_locked", DW'(locked), '0);
    check_out("los_err", DW'(err_count), DW'(1));
    check_out("los_beats", DW'(beats - b0), DW'(1));
  endtask

  task automatic test_reset_mid();
    int b0;
    do_reset();
    m_axis_tready = 1'b0;
    b0 = beats;
    send_one(WP);
    fill(20'h77777);
    send_frame(0);
    fill(20'h11111);
    send_range(0, 10);
    check_out("rmid_pre_tvalid", DW'(m_axis_tvalid), DW'(1));
    check_out("rmid_pre_locked", DW'(locked), DW'(1));
    do_reset();
    check_out("rmid_tvalid", DW'(m_axis_tvalid), '0);
    check_out("rmid_tlast", DW'(m_axis_tlast), '0);
    check_out("rmid_tdata", m_axis_tdata, '0);
    check_out("rmid_locked", DW'(locked), '0);
    check_out("rmid_err", DW'(err_count), '0);
    check_out("rmid_drop", DW'(drop_count), '0);
    m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_out("rmid_no_beat", DW'(beats - b0), '0);
  endtask

`ifdef IRIG_GLITCH_FILTER_EN
  task automatic test_glitch();
    int b0;
    do_reset();
    m_axis_tready = 1'b1;
    b0 = beats;
    send_one(WP);
    fill(20'h2468A);
    glitch_idx = 7;
    send_frame(1);
    glitch_idx = -1;
    send_one(WP);
    check_out("glitch_beats", DW'(beats - b0), DW'(1));
    check_out("glitch_err", DW'(err_count), '0);
    check_out("glitch_locked", DW'(locked), DW'(1));
  endtask
`endif

  initial begin
    test_reset();
    test_nominal_lock();
    test_back_pressure();
    test_bad_width();
    test_marker();
    test_los();
    test_reset_mid();
`ifdef IRIG_GLITCH_FILTER_EN
    test_glitch();
`endif
    check_out("final_pending", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/irig_frame_decoder.md
# irig_frame_decoder

Parametrised IRIG time-code frame decoder, successor to the fixed 50 MHz IRIG-B (B002) decoder. It classifies pulse-width-coded symbols for any clock frequency, bit rate and frame length. It locks on the double position-marker frame start and detects width, period, marker-position and loss-of-signal errors. Each frame is emitted on an AXI4-Stream master together with the free-running counter value latched at the pin-referred on-time edge, and the stream feeds the encoder timestamp path on the PS side.

## Interface
- CLK_FREQ_HZ, 50_000_000: clk frequency.
- BIT_RATE_HZ, 100: symbol rate (100 = IRIG-B, 1000 = IRIG-A).
- FRAME_BITS, 100: symbols per frame, multiple of 10.
- COUNTER_WIDTH, 64: timestamp width.
- GLITCH_CYCLES, 4: input filter length (only with IRIG_GLITCH_FILTER_EN).
- Derived: BIT_CYCLES = CLK_FREQ_HZ / BIT_RATE_HZ; LAT = 2 + GLITCH_CYCLES with filter, 2 without.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- counter_in  in  COUNTER_WIDTH  free-running timebase.
- irig_in  in  1  asynchronous IRIG DC-level input.
- m_axis_tdata  out  FRAME_BITS+COUNTER_WIDTH  [FRAME_BITS-1:0] symbol values, [FRAME_BITS +: COUNTER_WIDTH] timestamp.
- m_axis_tvalid  out  1  frame beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  equals m_axis_tvalid (one beat per frame).
- locked  out  1  decoder in frame lock.
- err_count  out  16  saturating error count.
- drop_count  out  16  saturating dropped-frame count.

## Operation
- Front end: 2-flop synchroniser, then optional filter. The filtered level changes only after GLITCH_CYCLES consecutive equal samples. Rising and falling edges are taken from the filtered level.
- Width counter: cleared on rise, saturates at 2*BIT_CYCLES. It is classified on fall, with thresholds fixed at elaboration as integer BIT_CYCLES*k/20:
  - width < 2/20 -> error.
  - < 7/20 -> '0'.
  - < 13/20 -> '1'.
  - < 18/20 -> 'P'.
  - otherwise -> error.
- Period counter: measures rise to rise. Outside HUNT, a period outside BIT_CYCLES ± BIT_CYCLES/16 -> error.
- Loss of signal: no rise for 2*BIT_CYCLES -> error.
- Symbol value into the frame vector: '1' -> 1; '0' and 'P' -> 0.
- FSM:
  - HUNT: on 'P' -> HUNT_P.
  - HUNT_P: on 'P', that symbol is Pr (index 0); latch its timestamp and go to LOCKED, index=1. On '0'/'1' -> HUNT.
  - LOCKED: store symbol at index. Index i with (i+1)%10==0 must be 'P'; every other index 1..FRAME_BITS-1 must not be 'P'; a violation is an error. After index FRAME_BITS-1 is stored, emit the frame and set index=0. The next symbol must be 'P' (new Pr): latch a new timestamp and set index=1.
- Error in HUNT_P or LOCKED: err_count++, go to HUNT, discard the partial frame. Errors in HUNT are ignored.
- locked=1 exactly while in LOCKED.
- Timestamp = counter_in − LAT (modulo 2^COUNTER_WIDTH), sampled in the cycle the filtered rise of Pr is detected, so it refers to the pin edge. Timestamps are candidates: every rise is latched, and the one belonging to Pr is kept.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, locked=0, err_count=0, drop_count=0, FSM=HUNT, index=0.
- Emission: tvalid rises 1 cycle after the detected fall of symbol FRAME_BITS-1. That fall is in turn LAT cycles after the pin fall.
- Output register holds tdata/tvalid stable until tvalid&tready.
- A new frame loads when tvalid=0, or in the same cycle tvalid&tready (no bubble).
- A new frame ready while tvalid=1 and tready=0: the new frame is dropped, drop_count++, and the held frame is untouched.
- Counters saturate at 0xFFFF.
- reset mid-frame: all state returns to reset values on the next edge, including a pending beat, which is discarded.

## Configuration
- IRIG_GLITCH_FILTER_EN defined: filter present, LAT = 2+GLITCH_CYCLES, and pulses shorter than GLITCH_CYCLES are invisible.
- IRIG_GLITCH_FILTER_EN undefined: synchroniser output used directly, LAT=2, and GLITCH_CYCLES is ignored.

## Test plan
All scenarios use defaults: BIT_CYCLES=500000; high times '0'=100000, '1'=250000, 'P'=400000 cycles.
- Nominal lock:
  - Stimulus: reset, then one 'P' symbol, then a 100-symbol frame (Pr, index 1 = '1', others '0' except markers), then the next frame's Pr.
  - Response: exactly one beat with tdata[1]=1 and all other symbol bits 0.
  - Response: timestamp = counter_in at the Pr pin rise, exactly.
  - Response: tlast=1, locked=1.
- Back-pressure:
  - Stimulus: tready=0 over two consecutive frames.
  - Response: first frame held unchanged, drop_count=1.
  - Response: after tready=1, exactly one beat is transferred.
- Bad width:
  - Stimulus: a 20000-cycle high pulse at index 40.
  - Response: err_count=1, locked=0, and no beat for that frame.
  - Response: relock and one good beat on the following frame.
- Marker position:
  - Stimulus: 'P' at index 5, or '0' at index 19.
  - Response: err_count +1, state HUNT, no beat.
- Loss of signal:
  - Stimulus: irig_in held low for 1000001 cycles while locked.
  - Response: locked=0, err_count +1.
- Reset mid-frame and glitch:
  - Stimulus: reset at index 50.
  - Response: all outputs are at their reset values.
  - Stimulus, with filter defined: a 2-cycle glitch.
  - Response: no effect on decoding.
